// File: rtl/memory_stage.sv
// memory_stage: rv32i MEM stage with EX/MEM register, single-outstanding dmem req/ack, store lane steering, load extension
// Ports: clk, rst (synchronous, active-high)
//        *E inputs        execute-stage fields captured into EX/MEM when StallM=0
//        StallM           upstream must hold while a memory access is pending
//        MisalignM        current op is a misaligned load/store (dropped, no write)
//        *M outputs       writeback-stage fields; RegWriteM is gated off while pending or misaligned
//        dmem_*           req/ack data-memory bus, one access in flight, ack is a one-cycle pulse
module memory_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic            MemWriteE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    output logic            StallM,
    output logic            MisalignM,
    output logic            RegWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] ReadDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack
);
    logic            reg_write_q;
    logic [1:0]      result_src_q;
    logic            mem_write_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] pc4_q;
    logic [4:0]      rd_q;
    logic            done_q;
    logic [XLEN-1:0] rdata_q;
    logic            memop;
    logic            is_byte;
    logic            is_half;
    logic            misalign;
    logic            access;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] load_val;
    logic [3:0]      store_be;
    logic [XLEN-1:0] store_data;

    always_comb begin
        memop      = (result_src_q == 2'b01) | mem_write_q;
        is_byte    = funct3_q[1:0] == 2'b00;
        is_half    = funct3_q[1:0] == 2'b01;
        // everything that is neither byte nor half, including undefined encodings, is a word
        misalign   = memop & (is_half ? alu_q[0] : ~is_byte & (alu_q[1:0] != 2'b00));
        access     = memop & ~done_q & ~misalign;
        byte_v     = dmem_rdata[{alu_q[1:0], 3'b000} +: 8];
        half_v     = dmem_rdata[{alu_q[1], 4'b0000} +: 16];
        // funct3[2] marks the unsigned load variants
        load_val   = is_byte ? {{(XLEN-8){byte_v[7] & ~funct3_q[2]}}, byte_v}
                   : is_half ? {{(XLEN-16){half_v[15] & ~funct3_q[2]}}, half_v}
                   : dmem_rdata;
        store_be   = is_byte ? 4'b0001 << alu_q[1:0] : is_half ? (alu_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        store_data = is_byte ? {4{wdata_q[7:0]}} : is_half ? {2{wdata_q[15:0]}} : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            mem_write_q  <= 1'b0;
            funct3_q     <= 3'b000;
            alu_q        <= '0;
            wdata_q      <= '0;
            pc4_q        <= '0;
            rd_q         <= 5'd0;
            done_q       <= 1'b0;
            rdata_q      <= '0;
        end else if (!access) begin
            reg_write_q  <= RegWriteE;
            result_src_q <= ResultSrcE;
            mem_write_q  <= MemWriteE;
            funct3_q     <= Funct3E;
            alu_q        <= ALUResultE;
            wdata_q      <= WriteDataE;
            pc4_q        <= PCPlus4E;
            rd_q         <= RdE;
            done_q       <= 1'b0;
        end else if (dmem_ack) begin
            done_q       <= 1'b1;
            rdata_q      <= load_val;
        end
    end

    assign StallM     = access;
    assign MisalignM  = misalign;
    assign RegWriteM  = reg_write_q & ~access & ~misalign;
    assign ResultSrcM = result_src_q;
    assign ALUResultM = alu_q;
    assign ReadDataM  = rdata_q;
    assign PCPlus4M   = pc4_q;
    assign RdM        = rd_q;
    assign dmem_req   = access;
    assign dmem_we    = access & mem_write_q;
    assign dmem_addr  = {alu_q[XLEN-1:2], 2'b00};
    assign dmem_be    = dmem_we ? store_be : 4'b0000;
    assign dmem_wdata = store_data;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed bench for memory_stage with a behavioural reference model and literal spot checks
module tb_memory_stage;
    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    op_t         e = '0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        StallM, MisalignM, RegWriteM, dmem_req, dmem_we;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, ReadDataM, PCPlus4M, dmem_addr, dmem_wdata;
    logic [4:0]  RdM;
    logic [3:0]  dmem_be;

    op_t         m = '0;
    logic        m_done = 1'b0;
    logic [31:0] m_rdata = '0;
    int          pass_n = 0;
    int          total_n = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        force_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          stall_seen = 0;
    int          n;
    logic        ld;

    memory_stage dut (
        .clk(clk), .rst(rst),
        .RegWriteE(e.rw), .ResultSrcE(e.rs), .MemWriteE(e.mw), .Funct3E(e.f3),
        .ALUResultE(e.alu), .WriteDataE(e.wd), .PCPlus4E(e.pc4), .RdE(e.rd),
        .StallM(StallM), .MisalignM(MisalignM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic op_t mk(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                               input logic [4:0] rd);
        op_t o;
        o.rw = rw; o.rs = rs; o.mw = mw; o.f3 = f3; o.alu = alu; o.wd = wd; o.pc4 = pc4; o.rd = rd;
        return o;
    endfunction

    function automatic int sz(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic is_mem(input op_t o);
        return o.rs == 2'b01 || o.mw;
    endfunction

    function automatic logic mis(input op_t o);
        return is_mem(o) && (int'(o.alu[1:0]) % sz(o.f3)) != 0;
    endfunction

    function automatic logic pend(input op_t o, input logic d);
        return is_mem(o) && !mis(o) && !d;
    endfunction

    function automatic logic [31:0] load_value(input op_t o, input logic [31:0] w);
        int     k;
        longint lim;
        longint v;
        k = sz(o.f3);
        lim = longint'(1) << (8 * k);
        v = (longint'(w) >> (8 * int'(o.alu[1:0]))) % lim;
        if (!o.f3[2] && k < 4 && v >= lim / 2) v = v - lim;
        return 32'(v);
    endfunction

    function automatic logic [31:0] be_exp(input op_t o);
        return 32'(((1 << sz(o.f3)) - 1) << int'(o.alu[1:0]));
    endfunction

    function automatic logic [31:0] wdata_exp(input op_t o);
        return sz(o.f3) == 1 ? {24'd0, o.wd[7:0]} * 32'h01010101
             : sz(o.f3) == 2 ? {16'd0, o.wd[15:0]} * 32'h00010001 : o.wd;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total_n++;
        if (act === exp_v) pass_n++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    task automatic check_model();
        logic p;
        logic w;
        p = pend(m, m_done);
        w = p && m.mw;
        chk("StallM", 32'(StallM), 32'(p));
        chk("MisalignM", 32'(MisalignM), 32'(mis(m)));
        chk("dmem_req", 32'(dmem_req), 32'(p));
        chk("dmem_we", 32'(dmem_we), 32'(w));
        chk("dmem_addr", dmem_addr, m.alu & ~32'h3);
        chk("dmem_be", 32'(dmem_be), w ? be_exp(m) : 32'h0);
        if (w) chk("dmem_wdata", dmem_wdata, wdata_exp(m));
        chk("RegWriteM", 32'(RegWriteM), 32'(m.rw && !p && !mis(m)));
        chk("ResultSrcM", 32'(ResultSrcM), 32'(m.rs));
        chk("ALUResultM", ALUResultM, m.alu);
        chk("PCPlus4M", PCPlus4M, m.pc4);
        chk("RdM", 32'(RdM), 32'(m.rd));
        chk("ReadDataM", ReadDataM, m_rdata);
    endtask

    // one clock: respond on the bus, advance the model across the edge, then compare
    task automatic tick(output logic loaded);
        dmem_ack = force_ack;
        if (dmem_req === 1'b1) begin
            if (wait_cnt == ack_delay) begin
                dmem_ack = 1'b1;
                wait_cnt = 0;
            end else wait_cnt++;
        end else wait_cnt = 0;
        dmem_rdata = mem_rdata;
        loaded = 1'b0;
        if (rst) begin
            m = '0; m_done = 1'b0; m_rdata = '0;
        end else if (!pend(m, m_done)) begin
            m = e; m_done = 1'b0; loaded = 1'b1;
        end else if (dmem_ack) begin
            m_done = 1'b1; m_rdata = load_value(m, dmem_rdata);
        end
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        force_ack = 1'b0;
        stall_seen += int'(StallM);
        check_model();
    endtask

    task automatic issue(input op_t o, output int cnt);
        logic l;
        e = o;
        cnt = 0;
        do begin
            tick(l);
            cnt++;
        end while (!l && cnt < 20);
        if (!l) begin
            total_n++;
            $display("FAIL issue timeout: op not accepted after %0d cycles", cnt);
        end
        e = '0;
    endtask

    initial begin
        rst = 1'b1;
        tick(ld);
        tick(ld);
        rst = 1'b0;
        chk("reset StallM", 32'(StallM), 32'h0);
        chk("reset dmem_req", 32'(dmem_req), 32'h0);
        chk("reset dmem_be", 32'(dmem_be), 32'h0);
        chk("reset RegWriteM", 32'(RegWriteM), 32'h0);
        chk("reset ReadDataM", ReadDataM, 32'h0);

        // SW 0x100, ack in first access cycle
        issue(mk(1'b0, 2'b00, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h4, 5'd0), n);
        chk("sw we", 32'(dmem_we), 32'h1);
        chk("sw be", 32'(dmem_be), 32'hF);
        chk("sw wdata", dmem_wdata, 32'hDEADBEEF);
        chk("sw addr", dmem_addr, 32'h100);
        chk("sw RegWriteM", 32'(RegWriteM), 32'h0);
        tick(ld);
        chk("sw stall one cycle", 32'(StallM), 32'h0);

        // SB 0x103
        issue(mk(1'b0, 2'b00, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h8, 5'd0), n);
        chk("sb be", 32'(dmem_be), 32'h8);
        chk("sb wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("sb addr", dmem_addr, 32'h100);
        tick(ld);

        // LB 0x202
        mem_rdata = 32'h0080FF00;
        issue(mk(1'b1, 2'b01, 1'b0, 3'b000, 32'h202, 32'h0, 32'h20, 5'd5), n);
        chk("lb pending RegWriteM", 32'(RegWriteM), 32'h0);
        tick(ld);
        chk("lb RegWriteM", 32'(RegWriteM), 32'h1);
        chk("lb ReadDataM", ReadDataM, 32'hFFFFFF80);

        // LHU 0x202
        issue(mk(1'b1, 2'b01, 1'b0, 3'b101, 32'h202, 32'h0, 32'h24, 5'd6), n);
        tick(ld);
        chk("lhu ReadDataM", ReadDataM, 32'h00000080);

        // LW with ack delayed 3 cycles, next ALU op held in EX
        mem_rdata = 32'h12345678;
        ack_delay = 3;
        issue(mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h300, 32'h0, 32'h28, 5'd7), n);
        stall_seen = int'(StallM);
        issue(mk(1'b1, 2'b00, 1'b0, 3'b000, 32'h55, 32'h0, 32'h40, 5'd8), n);
        ack_delay = 0;
        chk("lw stall cycles", 32'(stall_seen), 32'd4);
        chk("lw next held cycles", 32'(n), 32'd5);
        chk("alu after lw RdM", 32'(RdM), 32'd8);
        chk("lw data kept", ReadDataM, 32'h12345678);

        // misaligned LW 0x102 and SH 0x101
        issue(mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h102, 32'h0, 32'h44, 5'd9), n);
        chk("mis lw MisalignM", 32'(MisalignM), 32'h1);
        chk("mis lw req", 32'(dmem_req), 32'h0);
        chk("mis lw RegWriteM", 32'(RegWriteM), 32'h0);
        issue(mk(1'b0, 2'b00, 1'b1, 3'b001, 32'h101, 32'h1234, 32'h48, 5'd0), n);
        chk("mis lw one cycle", 32'(n), 32'd1);
        chk("mis sh be", 32'(dmem_be), 32'h0);
        issue('0, n);

        // spurious ack while idle must not touch ReadDataM
        mem_rdata = 32'hCAFEF00D;
        force_ack = 1'b1;
        tick(ld);
        chk("spurious ack", ReadDataM, 32'h12345678);

        // SH 0x002, LH 0x000, LBU 0x001, undefined-funct3 loads
        issue(mk(1'b0, 2'b00, 1'b1, 3'b001, 32'h002, 32'h1234BEEF, 32'h50, 5'd0), n);
        chk("sh be", 32'(dmem_be), 32'hC);
        chk("sh wdata", dmem_wdata, 32'hBEEFBEEF);
        mem_rdata = 32'h00008001;
        issue(mk(1'b1, 2'b01, 1'b0, 3'b001, 32'h000, 32'h0, 32'h54, 5'd10), n);
        tick(ld);
        chk("lh ReadDataM", ReadDataM, 32'hFFFF8001);
        mem_rdata = 32'h0000FF00;
        issue(mk(1'b1, 2'b01, 1'b0, 3'b100, 32'h001, 32'h0, 32'h58, 5'd11), n);
        tick(ld);
        chk("lbu ReadDataM", ReadDataM, 32'h000000FF);
        mem_rdata = 32'h89ABCDEF;
        issue(mk(1'b1, 2'b01, 1'b0, 3'b011, 32'h400, 32'h0, 32'h5C, 5'd12), n);
        tick(ld);
        chk("f3=011 as word", ReadDataM, 32'h89ABCDEF);
        issue(mk(1'b1, 2'b01, 1'b0, 3'b110, 32'h401, 32'h0, 32'h60, 5'd13), n);
        chk("f3=110 misaligned", 32'(MisalignM), 32'h1);

        // JAL-style PC+4 writeback passes straight through
        issue(mk(1'b1, 2'b10, 1'b0, 3'b000, 32'h1000, 32'h0, 32'h2004, 5'd1), n);
        chk("jal PCPlus4M", PCPlus4M, 32'h2004);
        chk("jal RegWriteM", 32'(RegWriteM), 32'h1);

        // reset during a pending load, then a late ack
        mem_rdata = 32'h11111111;
        ack_delay = 10;
        issue(mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h500, 32'h0, 32'h64, 5'd3), n);
        tick(ld);
        chk("pending req", 32'(dmem_req), 32'h1);
        rst = 1'b1;
        tick(ld);
        rst = 1'b0;
        chk("rst req", 32'(dmem_req), 32'h0);
        chk("rst StallM", 32'(StallM), 32'h0);
        chk("rst RdM", 32'(RdM), 32'h0);
        force_ack = 1'b1;
        tick(ld);
        chk("late ack RegWriteM", 32'(RegWriteM), 32'h0);
        chk("late ack ReadDataM", ReadDataM, 32'h0);
        ack_delay = 0;
        tick(ld);
        tick(ld);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
